// File: rtl/jp_pkg.sv
// Shared definitions for the NES joypad responder: button bit positions and frame phase.
package jp_pkg;

  localparam int unsigned JP_NUM_BUTTONS = 8;

  localparam int unsigned JP_A      = 0;
  localparam int unsigned JP_B      = 1;
  localparam int unsigned JP_SELECT = 2;
  localparam int unsigned JP_START  = 3;
  localparam int unsigned JP_UP     = 4;
  localparam int unsigned JP_DOWN   = 5;
  localparam int unsigned JP_LEFT   = 6;
  localparam int unsigned JP_RIGHT  = 7;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } frame_phase_e;

endpackage

// File: rtl/jp_line_filter.sv
// Synchroniser plus stability filter for one asynchronous pad line, with
// single-cycle rise/fall pulses derived from the accepted level.
module jp_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [3:0]             r_cnt;
  logic                   r_level;
  logic                   r_level_prev;
  logic                   w_sample;

  assign w_sample = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
    end
  end

  // r_cnt counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_cnt        <= '0;
      r_level      <= 1'b0;
      r_level_prev <= 1'b0;
    end else begin
      r_level_prev <= r_level;
      if (w_sample == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == FILT_LAST) begin
        r_level <= w_sample;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_prev;
  assign o_fall  = ~r_level & r_level_prev;

endmodule

// File: rtl/jp_responder.sv
// Controller-side NES joypad emulation: parallel button capture, serial shift-out on the
// console clock, A/B turbo and link-activity detection.
module jp_responder
  import jp_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FILT_LEN     = 4,
  parameter int unsigned TURBO_DIV    = 2,
  parameter int unsigned IDLE_TIMEOUT = 2500000
) (
  input  logic                      clk_in,
  input  logic                      nrst_in,
  input  logic [JP_NUM_BUTTONS-1:0] buttons_in,
  input  logic [1:0]                turbo_en_in,
  input  logic                      jp_latch_in,
  input  logic                      jp_clk_in,
  output logic                      jp_data_out,
  output logic [3:0]                shift_count_out,
  output logic                      frame_strobe_out,
  output logic                      link_active_out
);

  localparam int unsigned             IDLE_W    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0]       IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0]       IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [7:0]              TDIV_LAST = 8'(TURBO_DIV - 1);

  logic                      w_latch_lvl;
  logic                      w_latch_rise;
  logic                      w_latch_fall;
  logic                      w_clk_lvl;
  logic                      w_clk_rise;
  logic                      w_clk_fall;
  logic                      w_unused_clk;
  logic [JP_NUM_BUTTONS-1:0] w_eff;

  logic [JP_NUM_BUTTONS-1:0] r_sr;
  logic [3:0]                r_cnt;
  logic                      r_data;
  logic                      r_strobe;
  frame_phase_e              r_phase;
  logic [7:0]                r_tdiv;
  logic                      r_turbo_phase;
  logic [IDLE_W-1:0]         r_idle;
  logic                      r_active;

  jp_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_latch_filt (
    .i_clk   (clk_in),
    .i_nrst  (nrst_in),
    .i_line  (jp_latch_in),
    .o_level (w_latch_lvl),
    .o_rise  (w_latch_rise),
    .o_fall  (w_latch_fall)
  );

  jp_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_clk_filt (
    .i_clk   (clk_in),
    .i_nrst  (nrst_in),
    .i_line  (jp_clk_in),
    .o_level (w_clk_lvl),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall)
  );

  assign w_unused_clk = w_clk_lvl ^ w_clk_fall;

  always_comb begin
    w_eff = buttons_in;
    if (turbo_en_in[0]) w_eff[JP_A] = buttons_in[JP_A] & r_turbo_phase;
    if (turbo_en_in[1]) w_eff[JP_B] = buttons_in[JP_B] & r_turbo_phase;
  end

  // Data output is registered from the next shift-register value to keep the
  // raw-edge-to-pin latency at SYNC_STAGES+FILT_LEN+1.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      r_sr     <= '0;
      r_cnt    <= '0;
      r_data   <= 1'b1;
      r_strobe <= 1'b0;
      r_phase  <= LOAD;
    end else begin
      r_strobe <= w_latch_fall;
      if (w_latch_lvl) begin
        r_sr   <= w_eff;
        r_cnt  <= '0;
        r_data <= ~w_eff[0];
      end else if (w_clk_rise) begin
        r_sr   <= {1'b1, r_sr[JP_NUM_BUTTONS-1:1]};
        r_data <= ~r_sr[1];
        if (r_cnt != 4'd8) r_cnt <= r_cnt + 4'd1;
      end
      case (r_phase)
        LOAD: begin
          if (w_latch_fall) r_phase <= SHIFT;
        end
        SHIFT: begin
          if (w_latch_rise) r_phase <= LOAD;
          else if (w_clk_rise && r_cnt == 4'd7) r_phase <= TAIL;
        end
        TAIL: begin
          if (w_latch_rise) r_phase <= LOAD;
        end
        default: r_phase <= LOAD;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      r_tdiv        <= '0;
      r_turbo_phase <= 1'b0;
    end else if (w_latch_fall) begin
      if (r_tdiv == TDIV_LAST) begin
        r_tdiv        <= '0;
        r_turbo_phase <= ~r_turbo_phase;
      end else begin
        r_tdiv <= r_tdiv + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      r_idle   <= '0;
      r_active <= 1'b0;
    end else if (w_latch_fall) begin
      r_idle   <= '0;
      r_active <= 1'b1;
    end else begin
      if (r_idle != IDLE_MAX) r_idle <= r_idle + 1'b1;
      if (r_idle == IDLE_LAST) r_active <= 1'b0;
    end
  end

  assign jp_data_out      = r_data;
  assign shift_count_out  = r_cnt;
  assign frame_strobe_out = r_strobe;
  assign link_active_out  = r_active;

endmodule

// File: tb/tb_jp_responder.sv
// Directed bench for jp_responder: table-driven frames plus hand-written corner sequences.
module tb_jp_responder;

  logic       clk_in = 1'b0;
  logic       nrst_in = 1'b0;
  logic [7:0] buttons_in = 8'h00;
  logic [1:0] turbo_en_in = 2'b00;
  logic       jp_latch_in = 1'b0;
  logic       jp_clk_in = 1'b0;
  logic       jp_data_out;
  logic [3:0] shift_count_out;
  logic       frame_strobe_out;
  logic       link_active_out;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned last_strobe = 0;
  int unsigned n_strobe = 0;

  typedef struct {
    logic [7:0] buttons;
    logic [7:0] wire_bits;  // expected pin level for bits 0..7 (0 = pressed)
  } vec_t;

  vec_t vecs[5];

  always #20 clk_in = ~clk_in;

  jp_responder #(
    .SYNC_STAGES  (2),
    .FILT_LEN     (4),
    .TURBO_DIV    (2),
    .IDLE_TIMEOUT (1000)
  ) dut (
    .clk_in           (clk_in),
    .nrst_in          (nrst_in),
    .buttons_in       (buttons_in),
    .turbo_en_in      (turbo_en_in),
    .jp_latch_in      (jp_latch_in),
    .jp_clk_in        (jp_clk_in),
    .jp_data_out      (jp_data_out),
    .shift_count_out  (shift_count_out),
    .frame_strobe_out (frame_strobe_out),
    .link_active_out  (link_active_out)
  );

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (frame_strobe_out) begin
      last_strobe <= cyc;
      n_strobe    <= n_strobe + 1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic latch_pulse();
    jp_latch_in = 1'b1;
    cycles(12);
    jp_latch_in = 1'b0;
    cycles(12);
  endtask

  task automatic clk_pulse();
    jp_clk_in = 1'b1;
    cycles(12);
    jp_clk_in = 1'b0;
    cycles(12);
  endtask

  initial begin
    int unsigned strobes_before;
    int          guard;
    logic [7:0]  turbo_exp;

    vecs[0] = '{buttons: 8'b0000_1001, wire_bits: 8'b1111_0110};
    vecs[1] = '{buttons: 8'h00,        wire_bits: 8'hFF};
    vecs[2] = '{buttons: 8'hFF,        wire_bits: 8'h00};
    vecs[3] = '{buttons: 8'hA5,        wire_bits: 8'h5A};
    vecs[4] = '{buttons: 8'h80,        wire_bits: 8'h7F};

    #50;
    check("rst data", jp_data_out, 1);
    check("rst count", shift_count_out, 0);
    check("rst strobe", frame_strobe_out, 0);
    check("rst active", link_active_out, 0);
    @(posedge clk_in);
    #1 nrst_in = 1'b1;
    cycles(5);
    check("idle before first frame", link_active_out, 0);

    for (int v = 0; v < 5; v++) begin
      buttons_in = vecs[v].buttons;
      latch_pulse();
      check($sformatf("v%0d bit0", v), jp_data_out, vecs[v].wire_bits[0]);
      check($sformatf("v%0d count after latch", v), shift_count_out, 0);
      for (int b = 1; b < 8; b++) begin
        clk_pulse();
        check($sformatf("v%0d bit%0d", v, b), jp_data_out, vecs[v].wire_bits[b]);
      end
      check($sformatf("v%0d count7", v), shift_count_out, 7);
      clk_pulse();
      check($sformatf("v%0d tail data", v), jp_data_out, 0);
      check($sformatf("v%0d count8", v), shift_count_out, 8);
      clk_pulse();
      clk_pulse();
      check($sformatf("v%0d 10th data", v), jp_data_out, 0);
      check($sformatf("v%0d count sat", v), shift_count_out, 8);
    end
    check("link active after frames", link_active_out, 1);

    // Glitches shorter than the filter length on either line.
    buttons_in = 8'b0000_1001;
    latch_pulse();
    repeat (3) clk_pulse();
    check("pre-glitch count", shift_count_out, 3);
    check("pre-glitch data", jp_data_out, 0);
    strobes_before = n_strobe;
    jp_clk_in = 1'b1;
    cycles(2);
    jp_clk_in = 1'b0;
    cycles(20);
    check("clk glitch count", shift_count_out, 3);
    check("clk glitch data", jp_data_out, 0);
    buttons_in = 8'h00;
    jp_latch_in = 1'b1;
    cycles(2);
    jp_latch_in = 1'b0;
    cycles(20);
    check("latch glitch count", shift_count_out, 3);
    check("latch glitch data", jp_data_out, 0);
    check("latch glitch strobes", n_strobe, strobes_before);

    // Clock rise together with latch rise; buttons change while latch held.
    buttons_in = 8'h00;
    jp_latch_in = 1'b1;
    jp_clk_in = 1'b1;
    cycles(5);
    buttons_in = 8'h80;
    cycles(5);
    jp_clk_in = 1'b0;
    cycles(10);
    jp_latch_in = 1'b0;
    cycles(12);
    check("coinc count", shift_count_out, 0);
    check("coinc bit0", jp_data_out, 1);
    repeat (6) clk_pulse();
    check("coinc bit6", jp_data_out, 1);
    clk_pulse();
    check("coinc bit7 right", jp_data_out, 0);
    check("coinc count7", shift_count_out, 7);

    // Idle timeout measured from the last frame strobe.
    guard = 0;
    while ((cyc - last_strobe) < 995 && guard < 3000) begin
      cycles(1);
      guard++;
    end
    check("idle wait 995 in budget", (guard < 3000) ? 1 : 0, 1);
    check("active at 995", link_active_out, 1);
    guard = 0;
    while ((cyc - last_strobe) < 1005 && guard < 3000) begin
      cycles(1);
      guard++;
    end
    check("idle wait 1005 in budget", (guard < 3000) ? 1 : 0, 1);
    check("active at 1005", link_active_out, 0);
    latch_pulse();
    check("active restored", link_active_out, 1);

    // Asynchronous reset in the middle of a shift.
    buttons_in = 8'hFF;
    latch_pulse();
    repeat (3) clk_pulse();
    check("midshift data", jp_data_out, 0);
    check("midshift count", shift_count_out, 3);
    nrst_in = 1'b0;
    #1;
    check("async rst data", jp_data_out, 1);
    check("async rst count", shift_count_out, 0);
    check("async rst active", link_active_out, 0);
    cycles(2);
    nrst_in = 1'b1;
    cycles(3);
    buttons_in = 8'b0000_1001;
    latch_pulse();
    check("post-rst bit0", jp_data_out, 0);
    check("post-rst count", shift_count_out, 0);
    repeat (3) clk_pulse();
    check("post-rst bit3", jp_data_out, 0);
    check("post-rst count3", shift_count_out, 3);

    // Turbo on A from a clean reset: A pressed on frames 3,4,7,8.
    nrst_in = 1'b0;
    cycles(2);
    nrst_in = 1'b1;
    cycles(3);
    turbo_en_in = 2'b01;
    buttons_in  = 8'h01;
    turbo_exp   = 8'b0011_0011;
    for (int f = 0; f < 8; f++) begin
      latch_pulse();
      check($sformatf("turbo frame%0d", f + 1), jp_data_out, turbo_exp[f]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
